// File: rtl/core_types_pkg.sv
// Shared core sizing constants and physical-register tag types.
// Consumers: prf_wr_arbiter, rr_arbiter_nway and their benches.
package core_types_pkg;

    localparam int PRF_WR_COUNT       = 7;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
    localparam int PR_COUNT           = 128;
    localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
    localparam int XLEN               = 32;

    typedef logic [LOG_PR_COUNT-1:0]                    phys_reg_tag_t;
    typedef logic [LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] upper_phys_reg_tag_t;

endpackage

// File: rtl/rr_arbiter_nway.sv
// N-way round-robin arbiter: grants the first request at or after ptr,
// scanning upward modulo N. Purely combinational; one-hot (or zero) grant.
module rr_arbiter_nway
    import core_types_pkg::*;
#(
    parameter int N     = PRF_WR_COUNT,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx_s;
    logic found_s;

    // rotate the scan start to ptr and keep only the first hit
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s        = (int'(ptr) + k) % N;
            grant[idx_s] = req[idx_s] & ~found_s;
            found_s      = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/prf_wr_arbiter.sv
// Writeback-to-PRF arbiter: one write per bank per cycle, per-bank round-robin,
// PR 0 writes acknowledged and dropped. Build option: PRF_WR_ARB_FIXED_PRIO_EN.
module prf_wr_arbiter
    import core_types_pkg::*;
(
    input  logic                                                         CLK,
    input  logic                                                         nRST,
    input  logic [PRF_WR_COUNT-1:0]                                      WB_valid_by_req,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]                    WB_PR_by_req,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]                            WB_data_by_req,
    output logic [PRF_WR_COUNT-1:0]                                      WB_ready_by_req,
    output logic [PRF_BANK_COUNT-1:0]                                    PRF_WR_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] PRF_WR_upper_PR_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                          PRF_WR_data_by_bank,
    output logic [PRF_BANK_COUNT-1:0]                                    complete_valid,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]                  complete_PR_by_bank
);

    localparam int PTR_W = $clog2(PRF_WR_COUNT);

    logic [PRF_WR_COUNT-1:0]                       zero_req_s;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]   cand_s;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]   grant_s;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   win_pr_s;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]           win_data_s;

    logic [PRF_BANK_COUNT-1:0]                                      wr_valid_r;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] wr_upper_r;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                            wr_data_r;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]                    cpl_pr_r;

    // split valid requests into PR-0 drops and per-bank arbitration candidates
    always_comb begin
        zero_req_s = '0;
        cand_s     = '0;
        for (int r = 0; r < PRF_WR_COUNT; r++) begin
            zero_req_s[r] = WB_valid_by_req[r] & (WB_PR_by_req[r] == '0);
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                cand_s[b][r] = WB_valid_by_req[r] & (WB_PR_by_req[r] != '0) &
                    (WB_PR_by_req[r][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

`ifdef PRF_WR_ARB_FIXED_PRIO_EN
    // lowest-indexed candidate wins: isolate the least significant set bit
    for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank_prio
        assign grant_s[gb] = cand_s[gb] & (~cand_s[gb] + PRF_WR_COUNT'(1));
    end
`else
    logic [PRF_BANK_COUNT-1:0][PTR_W-1:0] rr_ptr_r;
    logic [PRF_BANK_COUNT-1:0][PTR_W-1:0] rr_ptr_nxt_s;
    logic [PRF_BANK_COUNT-1:0][PTR_W-1:0] win_idx_s;

    for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank_rr
        rr_arbiter_nway #(
            .N     (PRF_WR_COUNT),
            .PTR_W (PTR_W)
        ) u_arb (
            .req   (cand_s[gb]),
            .ptr   (rr_ptr_r[gb]),
            .grant (grant_s[gb])
        );
    end

    // pointer moves one past the winner, wrapping at PRF_WR_COUNT; idle banks hold
    always_comb begin
        win_idx_s    = '0;
        rr_ptr_nxt_s = rr_ptr_r;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int r = 0; r < PRF_WR_COUNT; r++) begin
                win_idx_s[b] = win_idx_s[b] | ({PTR_W{grant_s[b][r]}} & PTR_W'(r));
            end
            if (|grant_s[b]) begin
                if (win_idx_s[b] == PTR_W'(PRF_WR_COUNT - 1)) begin
                    rr_ptr_nxt_s[b] = '0;
                end else begin
                    rr_ptr_nxt_s[b] = win_idx_s[b] + PTR_W'(1);
                end
            end else begin
                rr_ptr_nxt_s[b] = rr_ptr_r[b];
            end
        end
    end

    // per-bank round-robin pointer state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_r <= '0;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end
`endif

    // ready: every PR-0 request plus each bank's single winner
    always_comb begin
        WB_ready_by_req = zero_req_s;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            WB_ready_by_req = WB_ready_by_req | grant_s[b];
        end
    end

    // AND-OR select of the winning PR and data per bank (zero when idle)
    always_comb begin
        win_pr_s   = '0;
        win_data_s = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int r = 0; r < PRF_WR_COUNT; r++) begin
                win_pr_s[b]   = win_pr_s[b]   | ({LOG_PR_COUNT{grant_s[b][r]}} & WB_PR_by_req[r]);
                win_data_s[b] = win_data_s[b] | ({XLEN{grant_s[b][r]}} & WB_data_by_req[r]);
            end
        end
    end

    // register the bank writes and the completion broadcast
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_valid_r <= '0;
            wr_upper_r <= '0;
            wr_data_r  <= '0;
            cpl_pr_r   <= '0;
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                wr_valid_r[b] <= |grant_s[b];
                wr_upper_r[b] <= win_pr_s[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                wr_data_r[b]  <= win_data_s[b];
                cpl_pr_r[b]   <= win_pr_s[b];
            end
        end
    end

    assign PRF_WR_valid_by_bank    = wr_valid_r;
    assign PRF_WR_upper_PR_by_bank = wr_upper_r;
    assign PRF_WR_data_by_bank     = wr_data_r;
    assign complete_valid          = wr_valid_r;
    assign complete_PR_by_bank     = cpl_pr_r;

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// Self-checking bench for prf_wr_arbiter: directed scenarios followed by
// randomized traffic scored against a per-bank round-robin reference model.
module tb_prf_wr_arbiter;
    import core_types_pkg::*;

    localparam int NR = PRF_WR_COUNT;
    localparam int NB = PRF_BANK_COUNT;
    localparam int UW = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    logic CLK;
    logic nRST;
    logic [NR-1:0]                   WB_valid_by_req;
    logic [NR-1:0][LOG_PR_COUNT-1:0] WB_PR_by_req;
    logic [NR-1:0][XLEN-1:0]         WB_data_by_req;
    logic [NR-1:0]                   WB_ready_by_req;
    logic [NB-1:0]                   PRF_WR_valid_by_bank;
    logic [NB-1:0][UW-1:0]           PRF_WR_upper_PR_by_bank;
    logic [NB-1:0][XLEN-1:0]         PRF_WR_data_by_bank;
    logic [NB-1:0]                   complete_valid;
    logic [NB-1:0][LOG_PR_COUNT-1:0] complete_PR_by_bank;

    prf_wr_arbiter dut (
        .CLK                     (CLK),
        .nRST                    (nRST),
        .WB_valid_by_req         (WB_valid_by_req),
        .WB_PR_by_req            (WB_PR_by_req),
        .WB_data_by_req          (WB_data_by_req),
        .WB_ready_by_req         (WB_ready_by_req),
        .PRF_WR_valid_by_bank    (PRF_WR_valid_by_bank),
        .PRF_WR_upper_PR_by_bank (PRF_WR_upper_PR_by_bank),
        .PRF_WR_data_by_bank     (PRF_WR_data_by_bank),
        .complete_valid          (complete_valid),
        .complete_PR_by_bank     (complete_PR_by_bank)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int            mptr  [NB];
    int            win   [NB];
    bit            exp_v [NB];
    int            exp_pr[NB];
    logic [31:0]   exp_d [NB];
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] last_rdy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        WB_valid_by_req = '0;
        WB_PR_by_req    = '0;
        WB_data_by_req  = '0;
    endtask

    task automatic set_req(input int r, input int pr, input logic [31:0] d);
        WB_valid_by_req[r] = 1'b1;
        WB_PR_by_req[r]    = LOG_PR_COUNT'(pr);
        WB_data_by_req[r]  = d;
    endtask

    // expected grants: per bank, first valid non-zero request at/after the pointer
    task automatic model_eval();
        exp_rdy = '0;
        for (int b = 0; b < NB; b++) begin
            exp_v[b] = 1'b0;
            win[b]   = 0;
            for (int k = 0; k < NR; k++) begin
                int r;
                int pr;
                r  = (mptr[b] + k) % NR;
                pr = int'(WB_PR_by_req[r]);
                if (!exp_v[b] && WB_valid_by_req[r] && pr != 0 && (pr % NB) == b) begin
                    exp_v[b]   = 1'b1;
                    win[b]     = r;
                    exp_pr[b]  = pr;
                    exp_d[b]   = WB_data_by_req[r];
                    exp_rdy[r] = 1'b1;
                end
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (WB_valid_by_req[r] && WB_PR_by_req[r] == '0) exp_rdy[r] = 1'b1;
        end
    endtask

    function automatic logic [NB-1:0] exp_vec();
        logic [NB-1:0] v;
        for (int b = 0; b < NB; b++) v[b] = exp_v[b];
        return v;
    endfunction

    // one clock: check combinational ready, then the registered writes after the edge
    task automatic cycle();
        #1;
        model_eval();
        chk("ready", 128'(WB_ready_by_req), 128'(exp_rdy));
        last_rdy = WB_ready_by_req;
        @(posedge CLK);
        #1;
        chk("wr_valid", 128'(PRF_WR_valid_by_bank), 128'(exp_vec()));
        chk("cpl_valid", 128'(complete_valid), 128'(exp_vec()));
        for (int b = 0; b < NB; b++) begin
            if (exp_v[b]) begin
                chk($sformatf("bank%0d_upper", b), 128'(PRF_WR_upper_PR_by_bank[b]), 128'(exp_pr[b] / NB));
                chk($sformatf("bank%0d_data", b), 128'(PRF_WR_data_by_bank[b]), 128'(exp_d[b]));
                chk($sformatf("bank%0d_cpl_pr", b), 128'(complete_PR_by_bank[b]), 128'(exp_pr[b]));
`ifndef PRF_WR_ARB_FIXED_PRIO_EN
                mptr[b] = (win[b] + 1) % NR;
`endif
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 128'(PRF_WR_valid_by_bank), 128'(0));
        chk({tag, "_cpl_valid"}, 128'(complete_valid), 128'(0));
        chk({tag, "_upper"}, 128'(PRF_WR_upper_PR_by_bank), 128'(0));
        chk({tag, "_data"}, 128'(PRF_WR_data_by_bank), 128'(0));
        chk({tag, "_cpl_pr"}, 128'(complete_PR_by_bank), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[3];
        for (int b = 0; b < NB; b++) mptr[b] = 0;
        nRST = 1'b0;
        clear_in();
        #12;
        chk_all_zero("reset");
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // single write
        clear_in();
        set_req(2, 5, 32'hDEADBEEF);
        cycle();
        chk("single_rdy", 128'(last_rdy), 128'(7'b0000100));
        chk("single_valid", 128'(PRF_WR_valid_by_bank), 128'(4'b0010));
        chk("single_upper", 128'(PRF_WR_upper_PR_by_bank[1]), 128'(5'd1));
        chk("single_data", 128'(PRF_WR_data_by_bank[1]), 128'(32'hDEADBEEF));
        chk("single_cpl_pr", 128'(complete_PR_by_bank[1]), 128'(7'h05));

        // same-bank contention, held until ready
        clear_in();
        set_req(0, 2, $urandom);
        set_req(3, 6, $urandom);
        set_req(6, 10, $urandom);
        order = '{0, 3, 6};
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("contend_grant%0d", i), 128'(last_rdy), 128'(1) << order[i]);
            WB_valid_by_req = WB_valid_by_req & ~exp_rdy;
        end

        // full parallelism
        clear_in();
        set_req(0, 4, 32'h1111_0000);
        set_req(1, 1, 32'h2222_0001);
        set_req(2, 2, 32'h3333_0002);
        set_req(3, 3, 32'h4444_0003);
        cycle();
        chk("par_rdy", 128'(last_rdy), 128'(7'b0001111));
        chk("par_valid", 128'(PRF_WR_valid_by_bank), 128'(4'b1111));

        // PR 0 writes
        clear_in();
        set_req(1, 0, 32'hAAAA_AAAA);
        set_req(4, 0, 32'h5555_5555);
        cycle();
        chk("pr0_rdy", 128'(last_rdy), 128'(7'b0010010));
        chk("pr0_valid", 128'(PRF_WR_valid_by_bank), 128'(4'b0000));
        chk("pr0_cpl_valid", 128'(complete_valid), 128'(4'b0000));

        // wrap-around on bank 0
        clear_in();
        set_req(5, 8, $urandom);
        cycle();
        clear_in();
        set_req(1, 12, $urandom);
        set_req(6, 16, $urandom);
        cycle();
        chk("wrap_first", 128'(last_rdy), 128'(7'b1000000));
        WB_valid_by_req = WB_valid_by_req & ~exp_rdy;
        cycle();
        chk("wrap_second", 128'(last_rdy), 128'(7'b0000010));

        // randomized traffic with hold-until-ready and occasional withdrawal
        clear_in();
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < NR; r++) begin
                if (WB_valid_by_req[r] && !exp_rdy[r]) begin
                    if ($urandom_range(0, 9) == 0) WB_valid_by_req[r] = 1'b0;
                end else begin
                    WB_valid_by_req[r] = ($urandom_range(0, 9) < 6);
                    if ($urandom_range(0, 7) == 0)
                        WB_PR_by_req[r] = '0;
                    else if ($urandom_range(0, 3) == 0)
                        WB_PR_by_req[r] = LOG_PR_COUNT'($urandom_range(1, PR_COUNT - 1));
                    else
                        WB_PR_by_req[r] = LOG_PR_COUNT'($urandom_range(1, 15));
                    WB_data_by_req[r] = $urandom;
                end
            end
            cycle();
        end

        // asynchronous reset while bank writes are registered
        clear_in();
        set_req(0, 4, 32'hCAFE_0000);
        set_req(1, 5, 32'hCAFE_0001);
        set_req(2, 6, 32'hCAFE_0002);
        set_req(3, 7, 32'hCAFE_0003);
        cycle();
        chk("prerst_valid", 128'(PRF_WR_valid_by_bank), 128'(4'b1111));
        #2;
        nRST = 1'b0;
        #1;
        chk_all_zero("async_rst");
        for (int b = 0; b < NB; b++) mptr[b] = 0;
        clear_in();
        set_req(0, 4, 32'h0BAD_F00D);
        set_req(5, 8, 32'h0000_0005);
        #1;
        nRST = 1'b1;
        cycle();
        chk("postrst_first", 128'(last_rdy), 128'(7'b0000001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
